// File: rtl/axi_mem_arbiter.sv
// Round-robin arbiter sharing one memory write channel and one read channel among NUM_REQ requesters.
// Read responses are steered back to the issuing requester by a tag pipeline matched to RD_LATENCY.
module axi_mem_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int RD_LATENCY = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_wr_valid,
  input  logic [NUM_REQ*32-1:0]   req_wr_addr,
  input  logic [NUM_REQ*32-1:0]   req_wr_data,
  output logic [NUM_REQ-1:0]      req_wr_ready,
  input  logic [NUM_REQ-1:0]      req_rd_valid,
  input  logic [NUM_REQ*32-1:0]   req_rd_addr,
  output logic [NUM_REQ-1:0]      req_rd_ready,
  output logic [NUM_REQ-1:0]      rsp_rd_valid,
  output logic [31:0]             rsp_rd_data,
  output logic                    m_write_valid,
  output logic [31:0]             m_write_addr,
  output logic [31:0]             m_write_data,
  input  logic                    m_write_ready,
  output logic                    m_read_valid,
  output logic [31:0]             m_read_addr,
  input  logic                    m_read_ready,
  input  logic [31:0]             m_read_data
);

  localparam int ID_W = $clog2(NUM_REQ);

  // Handshake: a transfer happens in a cycle where valid and ready are both high;
  // the requester holds valid/addr/data stable until it sees its ready bit.
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

  state_e            wr_state_q, wr_state_d;
  state_e            rd_state_q, rd_state_d;
  logic [ID_W-1:0]   wr_grant_q, wr_grant_d, wr_ptr_q, wr_ptr_d;
  logic [ID_W-1:0]   rd_grant_q, rd_grant_d, rd_ptr_q, rd_ptr_d;
  logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [ID_W-1:0]   tag_id_q [RD_LATENCY];
  logic [ID_W-1:0]   tag_id_d [RD_LATENCY];

  logic              wr_busy, rd_busy;
  logic              wr_sel_valid, rd_sel_valid;
  logic              wr_hs, rd_hs;
  logic [31:0]       wr_sel_addr, wr_sel_data, rd_sel_addr;

  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (id == ID_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // Lowest set request at or above ptr wins; otherwise wrap to the lowest set request.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] pick;
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) pick = ID_W'(i);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i] && (ID_W'(i) >= ptr)) pick = ID_W'(i);
    end
    return pick;
  endfunction

  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] g);
    logic [ID_W-1:0] n;
    if (g == ID_W'(NUM_REQ - 1)) n = '0;
    else                         n = g + 1'b1;
    return n;
  endfunction

  always_comb begin
    wr_sel_addr = '0;
    wr_sel_data = '0;
    rd_sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_grant_q == ID_W'(i)) begin
        wr_sel_addr = req_wr_addr[32*i +: 32];
        wr_sel_data = req_wr_data[32*i +: 32];
      end
      if (rd_grant_q == ID_W'(i)) begin
        rd_sel_addr = req_rd_addr[32*i +: 32];
      end
    end
  end

  assign wr_busy      = (wr_state_q == ST_BUSY);
  assign rd_busy      = (rd_state_q == ST_BUSY);
  assign wr_sel_valid = |(req_wr_valid & to_onehot(wr_grant_q));
  assign rd_sel_valid = |(req_rd_valid & to_onehot(rd_grant_q));

  assign m_write_valid = wr_busy && wr_sel_valid;
  assign m_write_addr  = wr_busy ? wr_sel_addr : 32'h0;
  assign m_write_data  = wr_busy ? wr_sel_data : 32'h0;
  assign m_read_valid  = rd_busy && rd_sel_valid;
  assign m_read_addr   = rd_busy ? rd_sel_addr : 32'h0;

  assign wr_hs = m_write_valid && m_write_ready;
  assign rd_hs = m_read_valid && m_read_ready;

  assign req_wr_ready = wr_hs ? to_onehot(wr_grant_q) : '0;
  assign req_rd_ready = rd_hs ? to_onehot(rd_grant_q) : '0;

  // Every grant is followed by an IDLE cycle so a ready registered from the
  // previous valid can never complete a second transfer.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_grant_d = wr_grant_q;
    wr_ptr_d   = wr_ptr_q;
    case (wr_state_q)
      ST_IDLE: begin
        if (|req_wr_valid) begin
          wr_grant_d = rr_pick(req_wr_valid, wr_ptr_q);
          wr_state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (wr_hs || !wr_sel_valid) begin
          wr_ptr_d   = rr_next(wr_grant_q);
          wr_state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_grant_d = rd_grant_q;
    rd_ptr_d   = rd_ptr_q;
    case (rd_state_q)
      ST_IDLE: begin
        if (|req_rd_valid) begin
          rd_grant_d = rr_pick(req_rd_valid, rd_ptr_q);
          rd_state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (rd_hs || !rd_sel_valid) begin
          rd_ptr_d   = rr_next(rd_grant_q);
          rd_state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Tag entry pushed in the read handshake cycle reaches the last stage exactly when memory data is valid.
  always_comb begin
    tag_vld_d[0] = rd_hs;
    tag_id_d[0]  = rd_grant_q;
    for (int k = 1; k < RD_LATENCY; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= ST_IDLE;
      rd_state_q <= ST_IDLE;
      wr_grant_q <= '0;
      rd_grant_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_vld_q  <= '0;
      for (int k = 0; k < RD_LATENCY; k++) tag_id_q[k] <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_grant_q <= wr_grant_d;
      rd_grant_q <= rd_grant_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tag_vld_q  <= tag_vld_d;
      for (int k = 0; k < RD_LATENCY; k++) tag_id_q[k] <= tag_id_d[k];
    end
  end

  assign rsp_rd_valid = tag_vld_q[RD_LATENCY-1] ? to_onehot(tag_id_q[RD_LATENCY-1]) : '0;
  assign rsp_rd_data  = m_read_data;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter against a small behavioural memory whose
// ready is registered from the previous cycle's valid and whose read data arrives RD_LATENCY cycles later.
module tb_axi_mem_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int RD_LATENCY = 3;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_wr_valid;
  logic [NUM_REQ*32-1:0] req_wr_addr;
  logic [NUM_REQ*32-1:0] req_wr_data;
  logic [NUM_REQ-1:0]    req_wr_ready;
  logic [NUM_REQ-1:0]    req_rd_valid;
  logic [NUM_REQ*32-1:0] req_rd_addr;
  logic [NUM_REQ-1:0]    req_rd_ready;
  logic [NUM_REQ-1:0]    rsp_rd_valid;
  logic [31:0]           rsp_rd_data;
  logic                  m_write_valid;
  logic [31:0]           m_write_addr;
  logic [31:0]           m_write_data;
  logic                  m_write_ready;
  logic                  m_read_valid;
  logic [31:0]           m_read_addr;
  logic                  m_read_ready;
  logic [31:0]           m_read_data;

  logic                  mem_full;
  logic [31:0]           mem [256];
  logic [31:0]           rd_pipe [RD_LATENCY];
  int                    cyc;
  int                    n_assert;
  int                    n_fail;

  typedef struct {
    logic [NUM_REQ-1:0] oh;
    logic [31:0]        addr;
    logic [31:0]        data;
    int                 cyc;
  } ev_t;

  ev_t wr_q[$];
  ev_t rd_q[$];
  ev_t rsp_q[$];

  axi_mem_arbiter #(.NUM_REQ(NUM_REQ), .RD_LATENCY(RD_LATENCY)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_wr_valid(req_wr_valid), .req_wr_addr(req_wr_addr), .req_wr_data(req_wr_data),
    .req_wr_ready(req_wr_ready),
    .req_rd_valid(req_rd_valid), .req_rd_addr(req_rd_addr), .req_rd_ready(req_rd_ready),
    .rsp_rd_valid(rsp_rd_valid), .rsp_rd_data(rsp_rd_data),
    .m_write_valid(m_write_valid), .m_write_addr(m_write_addr), .m_write_data(m_write_data),
    .m_write_ready(m_write_ready),
    .m_read_valid(m_read_valid), .m_read_addr(m_read_addr), .m_read_ready(m_read_ready),
    .m_read_data(m_read_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // behavioural memory: 1 KiB, MEMSIZEREG at 0x0, other registers read 0, out of range reads 0xDEADBEEF
  function automatic logic [31:0] mem_lookup(input logic [31:0] a);
    if (a == 32'h0)    return 32'd1024;
    if (a < 32'h10)    return 32'h0;
    if (a < 32'd1024)  return mem[a[9:2]];
    return 32'hDEADBEEF;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_write_ready <= 1'b0;
      m_read_ready  <= 1'b0;
      for (int k = 0; k < RD_LATENCY; k++) rd_pipe[k] <= 32'h0;
      for (int k = 0; k < 256; k++) mem[k] <= 32'h0;
    end else begin
      m_write_ready <= m_write_valid && !mem_full;
      m_read_ready  <= m_read_valid;
      if (m_write_valid && m_write_ready && m_write_addr >= 32'h10 && m_write_addr < 32'd1024)
        mem[m_write_addr[9:2]] <= m_write_data;
      rd_pipe[0] <= (m_read_valid && m_read_ready) ? mem_lookup(m_read_addr) : 32'h0;
      for (int k = 1; k < RD_LATENCY; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
  end

  assign m_read_data = rd_pipe[RD_LATENCY-1];

  // event recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_wr_ready != '0) wr_q.push_back('{req_wr_ready, m_write_addr, m_write_data, cyc});
      if (req_rd_ready != '0) rd_q.push_back('{req_rd_ready, m_read_addr, 32'h0, cyc});
      if (rsp_rd_valid != '0) rsp_q.push_back('{rsp_rd_valid, 32'h0, rsp_rd_data, cyc});
    end
  end

  // scoreboard helpers
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int sel);
    case (sel)
      0:       return wr_q.size();
      1:       return rd_q.size();
      default: return rsp_q.size();
    endcase
  endfunction

  task automatic wait_count(input int sel, input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (qsize(sel) < n && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    check(tag, 32'(qsize(sel)), 32'(n));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    wr_q.delete();
    rd_q.delete();
    rsp_q.delete();
  endtask

  initial begin
    cyc          = 0;
    n_assert     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    mem_full     = 1'b0;
    req_wr_valid = '0;
    req_wr_addr  = '0;
    req_wr_data  = '0;
    req_rd_valid = '0;
    req_rd_addr  = '0;

    // reset state
    #2;
    check("rst_m_write_valid", 32'(m_write_valid), 32'h0);
    check("rst_m_read_valid",  32'(m_read_valid),  32'h0);
    check("rst_req_wr_ready",  32'(req_wr_ready),  32'h0);
    check("rst_rsp_rd_valid",  32'(rsp_rd_valid),  32'h0);
    check("rst_rsp_rd_data",   rsp_rd_data,        32'h0);
    tick(2);
    rst_n = 1'b1;

    // reset mid-BUSY with a read tag in flight
    mem_full            = 1'b1;
    req_wr_valid[0]     = 1'b1;
    req_wr_addr[0+:32]  = 32'h100;
    req_wr_data[0+:32]  = 32'hC0DE_0000;
    req_rd_valid[0]     = 1'b1;
    req_rd_addr[0+:32]  = 32'h200;
    wait_count(1, 1, 20, "rst_rd_handshake");
    tick(1);
    check("pre_rst_wr_busy", 32'(m_write_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("midrst_m_write_valid", 32'(m_write_valid), 32'h0);
    check("midrst_m_write_addr",  m_write_addr,       32'h0);
    check("midrst_m_read_valid",  32'(m_read_valid),  32'h0);
    check("midrst_rsp_rd_valid",  32'(rsp_rd_valid),  32'h0);
    req_rd_valid = '0;
    mem_full     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_wr_addr[32*i +: 32] = 32'h100 + 32'(4 * i);
      req_wr_data[32*i +: 32] = 32'hC0DE_0000 + 32'(i);
    end
    req_wr_valid = 4'b1111;
    tick(1);
    clear_events();
    rst_n = 1'b1;

    // all four write continuously: grants 0,1,2,3,0 spaced 3 cycles
    wait_count(0, 5, 40, "rr_wr_count");
    tick(1);
    req_wr_valid = '0;
    for (int k = 0; k < 5 && k < wr_q.size(); k++) begin
      check($sformatf("rr_wr_grant_%0d", k), 32'(wr_q[k].oh), 32'(4'b0001 << (k % 4)));
      check($sformatf("rr_wr_addr_%0d", k), wr_q[k].addr, 32'h100 + 32'(4 * (k % 4)));
      check($sformatf("rr_wr_data_%0d", k), wr_q[k].data, 32'hC0DE_0000 + 32'(k % 4));
      if (k > 0) check($sformatf("rr_wr_spacing_%0d", k), 32'(wr_q[k].cyc - wr_q[k-1].cyc), 32'd3);
    end
    check("rst_tag_discarded", 32'(rsp_q.size()), 32'h0);
    for (int i = 0; i < NUM_REQ; i++)
      check($sformatf("mem_word_%0h", 8'h40 + i), mem[8'h40 + i], 32'hC0DE_0000 + 32'(i));

    // req2 writes 0x200 then reads it back
    clear_events();
    req_wr_valid[2]     = 1'b1;
    req_wr_addr[64+:32] = 32'h200;
    req_wr_data[64+:32] = 32'hA5A5_0002;
    wait_count(0, 1, 20, "r2_wr_count");
    tick(1);
    req_wr_valid = '0;
    if (wr_q.size() > 0) check("r2_wr_grant", 32'(wr_q[0].oh), 32'h4);
    clear_events();
    req_rd_valid[2]     = 1'b1;
    req_rd_addr[64+:32] = 32'h200;
    wait_count(1, 1, 20, "r2_rd_count");
    tick(1);
    req_rd_valid = '0;
    wait_count(2, 1, 10, "r2_rsp_count");
    if (rd_q.size() > 0 && rsp_q.size() > 0) begin
      check("r2_rd_grant",   32'(rd_q[0].oh),   32'h4);
      check("r2_rsp_valid",  32'(rsp_q[0].oh),  32'h4);
      check("r2_rsp_data",   rsp_q[0].data,     32'hA5A5_0002);
      check("r2_rsp_latency", 32'(rsp_q[0].cyc - rd_q[0].cyc), 32'(RD_LATENCY));
    end

    // req1 and req3 read back-to-back: size register then out of range
    clear_events();
    req_rd_valid[1]     = 1'b1;
    req_rd_addr[32+:32] = 32'h000;
    tick(1);
    req_rd_valid[3]     = 1'b1;
    req_rd_addr[96+:32] = 32'hFFC;
    wait_count(1, 1, 20, "b2b_rd1_count");
    tick(1);
    req_rd_valid[1] = 1'b0;
    wait_count(1, 2, 20, "b2b_rd2_count");
    tick(1);
    req_rd_valid[3] = 1'b0;
    wait_count(2, 2, 20, "b2b_rsp_count");
    if (rd_q.size() > 1 && rsp_q.size() > 1) begin
      check("b2b_rd_grant_a",  32'(rd_q[0].oh),  32'h2);
      check("b2b_rd_grant_b",  32'(rd_q[1].oh),  32'h8);
      check("b2b_rsp_valid_a", 32'(rsp_q[0].oh), 32'h2);
      check("b2b_rsp_data_a",  rsp_q[0].data,    32'd1024);
      check("b2b_rsp_valid_b", 32'(rsp_q[1].oh), 32'h8);
      check("b2b_rsp_data_b",  rsp_q[1].data,    32'hDEADBEEF);
    end

    // memory backpressure: grant held on req1 while req3 waits
    clear_events();
    mem_full            = 1'b1;
    req_wr_valid[1]     = 1'b1;
    req_wr_addr[32+:32] = 32'h180;
    req_wr_data[32+:32] = 32'h5555_0001;
    tick(2);
    req_wr_valid[3]     = 1'b1;
    req_wr_addr[96+:32] = 32'h1C0;
    req_wr_data[96+:32] = 32'h5555_0003;
    tick(6);
    check("bp_no_ready",    32'(wr_q.size()),     32'h0);
    check("bp_valid_held",  32'(m_write_valid),   32'h1);
    check("bp_grant_held",  m_write_addr,         32'h180);
    mem_full = 1'b0;
    wait_count(0, 1, 10, "bp_wr1_count");
    tick(1);
    req_wr_valid[1] = 1'b0;
    wait_count(0, 2, 10, "bp_wr2_count");
    tick(1);
    req_wr_valid[3] = 1'b0;
    if (wr_q.size() > 1) begin
      check("bp_grant_a", 32'(wr_q[0].oh), 32'h2);
      check("bp_grant_b", 32'(wr_q[1].oh), 32'h8);
    end
    check("bp_mem_60", mem[8'h60], 32'h5555_0001);
    check("bp_mem_70", mem[8'h70], 32'h5555_0003);

    // req1 withdraws while granted; req2 is served next
    clear_events();
    mem_full            = 1'b1;
    req_wr_valid[1]     = 1'b1;
    req_wr_addr[32+:32] = 32'h300;
    req_wr_data[32+:32] = 32'h1111_1111;
    req_wr_valid[2]     = 1'b1;
    req_wr_addr[64+:32] = 32'h340;
    req_wr_data[64+:32] = 32'h2222_2222;
    tick(2);
    check("wd_granted_req1", m_write_addr, 32'h300);
    req_wr_valid[1] = 1'b0;
    mem_full        = 1'b0;
    wait_count(0, 1, 12, "wd_wr_count");
    tick(1);
    req_wr_valid[2] = 1'b0;
    tick(3);
    check("wd_total_handshakes", 32'(wr_q.size()), 32'h1);
    if (wr_q.size() > 0) begin
      check("wd_next_grant", 32'(wr_q[0].oh), 32'h4);
      check("wd_next_addr",  wr_q[0].addr,    32'h340);
    end
    check("wd_mem_c0", mem[8'hC0], 32'h0);
    check("wd_mem_d0", mem[8'hD0], 32'h2222_2222);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
